// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared fetch/decode types, opcodes and compact-instruction classes
package common_pkg;

   localparam logic [1:0]  REG_PRIME_BASE = 2'b01;
   localparam logic [31:0] INSTR_HALT     = 32'hFFFF_FFFF;

   typedef logic [15:0] fetch_hw_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        illegal;
   } compact_expand_t;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } normal_instructions_t;

   // Class key is {funct3, quadrant, bit12-only-for-the-CR-group}.
   typedef enum logic [5:0] {
      COMPACT_ADDI4SPN     = 6'b000_00_0,
      COMPACT_LW           = 6'b010_00_0,
      COMPACT_SW           = 6'b110_00_0,
      COMPACT_ADDI         = 6'b000_01_0,
      COMPACT_JAL          = 6'b001_01_0,
      COMPACT_LI           = 6'b010_01_0,
      COMPACT_LUI_ADDI16SP = 6'b011_01_0,
      COMPACT_MISC_ALU     = 6'b100_01_0,
      COMPACT_J            = 6'b101_01_0,
      COMPACT_BEQZ         = 6'b110_01_0,
      COMPACT_BNEZ         = 6'b111_01_0,
      COMPACT_SLLI         = 6'b000_10_0,
      COMPACT_LWSP         = 6'b010_10_0,
      COMPACT_JR_MV        = 6'b100_10_0,
      COMPACT_JALR_ADD     = 6'b100_10_1,
      COMPACT_SWSP         = 6'b110_10_0
   } compact_instructions_t;

endpackage

// File: rtl/compact_expander.sv
// rtl/compact_expander.sv - combinational expansion of one 16-bit instruction to its 32-bit form
module compact_expander
   import common_pkg::*;
(
   input  fetch_hw_t       hw,
   output compact_expand_t result
);

   logic [5:0]  key;
   logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
   logic [31:0] ins;
   logic        bad;

   assign rd   = hw[11:7];
   assign rs2  = hw[6:2];
   assign rdp  = {REG_PRIME_BASE, hw[4:2]};
   assign rs2p = {REG_PRIME_BASE, hw[4:2]};
   assign rs1p = {REG_PRIME_BASE, hw[9:7]};

   always_comb begin
      ins = 32'h0;
      bad = 1'b0;
      key = {hw[15:13], hw[1:0], (hw[15:13] == 3'b100 && hw[1:0] == 2'b10) ? hw[12] : 1'b0};
      case (key)
         COMPACT_ADDI4SPN: begin
            ins = {2'b00, hw[10:7], hw[12:11], hw[5], hw[6], 2'b00, 5'd2, 3'b000, rdp, OPC_OP_IMM};
            bad = (hw[12:5] == 8'h00);
         end
         COMPACT_LW:   ins = {5'b0, hw[5], hw[12:10], hw[6], 2'b00, rs1p, 3'b010, rdp, OPC_LOAD};
         COMPACT_SW:   ins = {5'b0, hw[5], hw[12], rs2p, rs1p, 3'b010, hw[11:10], hw[6], 2'b00, OPC_STORE};
         COMPACT_ADDI: ins = {{7{hw[12]}}, hw[6:2], rd, 3'b000, rd, OPC_OP_IMM};
         COMPACT_JAL, COMPACT_J:
            ins = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3], hw[12],
                   {8{hw[12]}}, 4'b0000, ~hw[15], OPC_JAL};
         COMPACT_LI:   ins = {{7{hw[12]}}, hw[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
         COMPACT_LUI_ADDI16SP: begin
            bad = ({hw[12], hw[6:2]} == 6'h00);
            if (rd == 5'd2)
               ins = {{3{hw[12]}}, hw[4:3], hw[5], hw[2], hw[6], 4'b0000, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            else
               ins = {{15{hw[12]}}, hw[6:2], rd, OPC_LUI};
         end
         COMPACT_MISC_ALU: begin
            case (hw[11:10])
               2'b00, 2'b01: begin
                  ins = {1'b0, hw[10], 5'b0, hw[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                  bad = hw[12];
               end
               2'b10: ins = {{7{hw[12]}}, hw[6:2], rs1p, 3'b111, rs1p, OPC_OP_IMM};
               default: begin
                  ins = {1'b0, hw[6:5] == 2'b00, 5'b0, rs2p, rs1p,
                         (hw[6:5] == 2'b00) ? 3'b000 : {1'b1, hw[6], hw[6] & hw[5]}, rs1p, OPC_OP};
                  bad = hw[12];
               end
            endcase
         end
         COMPACT_BEQZ, COMPACT_BNEZ:
            ins = {{4{hw[12]}}, hw[6:5], hw[2], 5'd0, rs1p, 2'b00, hw[13], hw[11:10], hw[4:3], hw[12], OPC_BRANCH};
         COMPACT_SLLI: begin
            ins = {7'b0, hw[6:2], rd, 3'b001, rd, OPC_OP_IMM};
            bad = hw[12];
         end
         COMPACT_LWSP: begin
            ins = {4'b0, hw[3:2], hw[12], hw[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD};
            bad = (rd == 5'd0);
         end
         COMPACT_SWSP: ins = {4'b0, hw[8:7], hw[12], rs2, 5'd2, 3'b010, hw[11:9], 2'b00, OPC_STORE};
         COMPACT_JR_MV: begin
            if (rs2 == 5'd0) begin
               ins = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
               bad = (rd == 5'd0);
            end else
               ins = {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP};
         end
         COMPACT_JALR_ADD: begin
            // rs1==0 here is c.ebreak, which has no expansion in this datapath
            if (rs2 == 5'd0) begin
               ins = {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
               bad = (rd == 5'd0);
            end else
               ins = {7'b0, rs2, rd, 3'b000, rd, OPC_OP};
         end
         default: bad = 1'b1;
      endcase
   end

   assign result = '{instr: bad ? {16'h0000, hw} : ins, illegal: bad};

endmodule

// File: rtl/instr_realigner.sv
// rtl/instr_realigner.sv - halfword fetch queue presenting aligned, expanded instructions with PC
module instr_realigner
   import common_pkg::*;
#(
   parameter int FETCH_BYTES = 4,
   parameter int BUF_HW      = 6,
   parameter bit C_EXT_EN    = 1'b1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     fetch_valid,
   output logic                     fetch_ready,
   input  logic [FETCH_BYTES*8-1:0] fetch_data,
   input  logic [31:0]              fetch_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc,
   output logic                     instr_is_compact,
   output logic                     instr_illegal
);

   localparam int FETCH_HW = FETCH_BYTES / 2;
   localparam int PW       = $clog2(BUF_HW);
   localparam int CW       = $clog2(BUF_HW + 1);
   localparam int OFF_W    = $clog2(FETCH_BYTES) - 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   fetch_hw_t       buf_q [BUF_HW];
   fetch_hw_t       buf_d [BUF_HW];
   ptr_t            head_q, head_d, tail_q, tail_d;
   cnt_t            count_q, count_d;
   logic [31:0]     head_pc_q, head_pc_d;
   logic            restart_q, restart_d;
   fetch_hw_t       h0, h1;
   logic            head_is32, push, pop;
   cnt_t            drop_n, push_n, pop_n;
   compact_expand_t exp_res;

   // Non-power-of-two depth: wrap by subtraction rather than truncation.
   function automatic ptr_t ptr_add(input ptr_t p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= BUF_HW) s = s - BUF_HW;
      return ptr_t'(s);
   endfunction

   always_comb begin
      h0 = buf_q[head_q];
      h1 = buf_q[ptr_add(head_q, 1)];
   end

   assign head_is32   = (h0[1:0] == 2'b11);
   assign instr_valid = rst_n && !flush && (head_is32 ? (count_q >= cnt_t'(2)) : (count_q != '0));
   assign fetch_ready = rst_n && !flush && (int'(count_q) <= BUF_HW - FETCH_HW);
   assign push        = fetch_valid && fetch_ready;
   assign pop         = instr_valid && instr_ready;
   assign drop_n      = restart_q ? cnt_t'(fetch_pc[OFF_W:1]) : '0;
   assign push_n      = cnt_t'(FETCH_HW) - drop_n;
   assign pop_n       = head_is32 ? cnt_t'(2) : cnt_t'(1);

   always_comb begin
      buf_d = buf_q;
      if (push) begin
         for (int i = 0; i < FETCH_HW; i++) begin
            if (i >= int'(drop_n))
               buf_d[ptr_add(tail_q, i - int'(drop_n))] = fetch_data[16*i +: 16];
         end
      end
   end

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      head_pc_d = head_pc_q;
      restart_d = restart_q;
      count_d   = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
      if (push) begin
         tail_d = ptr_add(tail_q, int'(push_n));
         if (restart_q) begin
            head_pc_d = fetch_pc;
            restart_d = 1'b0;
         end
      end
      if (pop) begin
         head_d    = ptr_add(head_q, int'(pop_n));
         head_pc_d = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
      end
      if (flush) begin
         count_d   = '0;
         tail_d    = head_q;
         restart_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         head_pc_q <= 32'h0;
         restart_q <= 1'b1;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         head_pc_q <= head_pc_d;
         restart_q <= restart_d;
      end
   end

   compact_expander u_expander (
      .hw     (h0),
      .result (exp_res)
   );

   assign instr_is_compact = !head_is32;
   assign instr_illegal    = !head_is32 && (!C_EXT_EN || exp_res.illegal);
   assign instr_pc         = head_pc_q;
   assign instr            = head_is32     ? {h1, h0} :
                             instr_illegal ? {16'h0000, h0} : exp_res.instr;

endmodule
